pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

- Holds both players' scores and runs the match state machine: idle, play, game over.
- Drives six 4-bit display codes. Each code feeds one seven-segment decoder instance that renders a HEX digit, so the codes follow that decoder's code set: 0–9 digits, 10 blank, 11 '-', 12 'P'.
- Sits between the game logic (ball/paddle collision, which emits point pulses) and the HEX display decoders.

## Interface
- WIN_SCORE, 7: score that ends the match; legal range 1–9.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period in game over; minimum 2.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- new_game  input  1  single-cycle pulse; clears scores and starts a match.
- point_p1  input  1  single-cycle pulse; player 1 scored.
- point_p2  input  1  single-cycle pulse; player 2 scored.
- digit5 … digit0  output  4 each  display codes, digit5 leftmost; registered.
- game_over  output  1  high in OVER state; registered.
- winner  output  2  0 none, 1 player 1, 2 player 2; registered.

## Operation
- Score registers p1_score, p2_score: 4 bits each, range 0..WIN_SCORE.
- States:
  - IDLE (reset state).
  - PLAY.
  - OVER.
- Transitions:
  - new_game in any state → PLAY, both scores 0, winner 0. new_game has priority over same-cycle points.
  - PLAY, point_p1 only → p1_score+1. If the result equals WIN_SCORE → OVER, winner=1.
  - PLAY, point_p2 only → symmetric; winner=2.
  - PLAY, point_p1 and point_p2 in the same cycle → ignored; no score change.
  - IDLE and OVER ignore point pulses; scores hold.
- Scores never exceed WIN_SCORE and never wrap.
- Display map per state:
  - IDLE: all six digits = 11 ('------').
  - PLAY: d5=p1_score, d4=10, d3=11, d2=11, d1=10, d0=p2_score.
  - OVER, blink phase on: d5=12 ('P'), d4=winner, d3=10, d2=p1_score, d1=11, d0=p2_score.
  - OVER, blink phase off: same as phase on, except d5=d4=10.
- Blink counter runs only in OVER:
  - Counts 0..BLINK_DIV-1.
  - On wrap it toggles phase.
  - Entering OVER clears the counter and sets phase on.
  - Held at 0 / phase on in IDLE and PLAY.

## Timing
- Reset (asynchronous):
  - state=IDLE, scores 0, winner=0, game_over=0.
  - All digits=11; blink counter 0, phase on.
- Input pulse sampled at edge k: state, scores and winner update at edge k.
- digit outputs and game_over are registered from the post-update state and change at edge k+1. Display latency is 2 edges from the pulse-sampling edge.
- Winning point at edge k: state=OVER and winner valid after edge k; game_over=1 after edge k+1.
- Blink: the first phase-off begins BLINK_DIV cycles after the OVER entry edge, then alternates every BLINK_DIV cycles.
- Pulses held high for several cycles count once per cycle. Upstream guarantees single-cycle pulses.
- Reset asserted mid-match: immediate return to IDLE values, no clock required.
- Outputs show 11 until the first clk edge after reset deasserts.

## Configuration
- SCORE_BLINK_EN defined: blink counter and phase logic are present, behaving as above.
- SCORE_BLINK_EN undefined:
  - No blink counter is synthesized.
  - OVER always shows the phase-on map.
  - BLINK_DIV is accepted but unused.

## Test plan
- Reset then idle 5 cycles → all digits 11, game_over=0, winner=0. Points in IDLE leave everything unchanged.
- new_game, then 3× point_p1 and 2× point_p2 → after 2 edges: d5=3, d4=10, d3=11, d2=11, d1=10, d0=2.
- WIN_SCORE=7, p1 reaches 7 →
  - winner=1.
  - game_over=1 one edge later.
  - digits 12,1,10,7,11,p2_score.
  - Further point_p2 ignored.
- point_p1 and point_p2 in the same PLAY cycle → scores unchanged. new_game together with point_p1 → scores 0, state PLAY.
- SCORE_BLINK_EN defined, BLINK_DIV=4, in OVER:
  - d5/d4 alternate between (12, winner) and (10, 10) every 4 cycles, starting with phase on.
  - With the macro undefined: steady (12, winner).
- Reset asserted asynchronously between clock edges mid-PLAY → outputs return to IDLE values before the next edge. new_game afterwards starts a clean 0–0 match.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Pong score keeper: tracks both players' scores, runs the IDLE/PLAY/OVER match FSM and drives six HEX display codes.
// Optional feature macro SCORE_BLINK_EN: blinks the winner banner (d5/d4) in OVER with a BLINK_DIV-cycle half-period.
module pong_score_keeper #(
  parameter int WIN_SCORE = 7,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] digit5,
  output logic [3:0] digit4,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_DASH  = 4'd11;
  localparam logic [3:0] CODE_P     = 4'd12;

  generate
    if (WIN_SCORE < 1 || WIN_SCORE > 9 || BLINK_DIV < 2) begin : g_bad_param
      $error("pong_score_keeper: WIN_SCORE must be 1..9 and BLINK_DIV at least 2");
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [3:0] p1_score_reg, p1_score_next;
  logic [3:0] p2_score_reg, p2_score_next;
  logic [1:0] winner_next;
  logic       phase_on;

  // Match FSM and score update; new_game wins over any same-cycle point.
  always_comb begin
    state_next    = state_reg;
    p1_score_next = p1_score_reg;
    p2_score_next = p2_score_reg;
    winner_next   = winner;
    if (new_game) begin
      state_next    = PLAY;
      p1_score_next = 4'd0;
      p2_score_next = 4'd0;
      winner_next   = 2'd0;
    end else if (state_reg == PLAY) begin
      if (point_p1 && !point_p2) begin
        p1_score_next = p1_score_reg + 4'd1;
        if (p1_score_next == WIN4) begin
          state_next  = OVER;
          winner_next = 2'd1;
        end
      end else if (point_p2 && !point_p1) begin
        p2_score_next = p2_score_reg + 4'd1;
        if (p2_score_next == WIN4) begin
          state_next  = OVER;
          winner_next = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      p1_score_reg <= 4'd0;
      p2_score_reg <= 4'd0;
      winner       <= 2'd0;
    end else begin
      state_reg    <= state_next;
      p1_score_reg <= p1_score_next;
      p2_score_reg <= p2_score_next;
      winner       <= winner_next;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blink_cnt_reg;
  logic             phase_reg;

  // Counter only advances while already in OVER, so the entry edge leaves it at 0 / phase on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (new_game || state_reg != OVER) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (blink_cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  assign phase_on = phase_reg;
`else
  assign phase_on = 1'b1;
`endif

  logic [3:0] digits_next [6];
  logic [3:0] digits_reg  [6];

  // Display map is taken from the registered (post-update) state, adding one edge of latency.
  always_comb begin
    for (int i = 0; i < 6; i++) digits_next[i] = CODE_DASH;
    case (state_reg)
      PLAY: begin
        digits_next[5] = p1_score_reg;
        digits_next[4] = CODE_BLANK;
        digits_next[1] = CODE_BLANK;
        digits_next[0] = p2_score_reg;
      end
      OVER: begin
        digits_next[5] = phase_on ? CODE_P : CODE_BLANK;
        digits_next[4] = phase_on ? {2'b00, winner} : CODE_BLANK;
        digits_next[3] = CODE_BLANK;
        digits_next[2] = p1_score_reg;
        digits_next[0] = p2_score_reg;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      always_ff @(posedge clk or posedge reset) begin
        if (reset) digits_reg[gi] <= CODE_DASH;
        else       digits_reg[gi] <= digits_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) game_over <= 1'b0;
    else       game_over <= (state_reg == OVER);
  end

  assign digit5 = digits_reg[5];
  assign digit4 = digits_reg[4];
  assign digit3 = digits_reg[3];
  assign digit2 = digits_reg[2];
  assign digit1 = digits_reg[1];
  assign digit0 = digits_reg[0];

endmodule

// File: tb/tb_pong_score_keeper.sv
// Self-checking bench for pong_score_keeper: a behavioural model pushes expected outputs per cycle, compared after each edge.
// Honours SCORE_BLINK_EN the same way as the design (BLINK_DIV=4 here).
module tb_pong_score_keeper;
  localparam int WIN  = 7;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       reset, new_game, point_p1, point_p2;
  logic [3:0] digit5, digit4, digit3, digit2, digit1, digit0;
  logic       game_over;
  logic [1:0] winner;

  pong_score_keeper #(.WIN_SCORE(WIN), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .point_p1(point_p1), .point_p2(point_p2),
    .digit5(digit5), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] disp;
    logic        go;
    logic [1:0]  win;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 play, 2 over
  int          m_state;
  int          m_p1, m_p2, m_win, m_cnt;
  bit          m_phase;
  logic [23:0] m_disp;
  logic        m_go;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] idle_disp();
    return {4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11};
  endfunction

  function automatic logic [23:0] map_disp();
    logic [3:0] a5, a4;
    if (m_state == 1)
      return {4'(m_p1), 4'd10, 4'd11, 4'd11, 4'd10, 4'(m_p2)};
    if (m_state == 2) begin
      a5 = m_phase ? 4'd12 : 4'd10;
      a4 = m_phase ? 4'(m_win) : 4'd10;
      return {a5, a4, 4'd10, 4'(m_p1), 4'd11, 4'(m_p2)};
    end
    return idle_disp();
  endfunction

  task automatic model_reset();
    m_state = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_cnt = 0; m_phase = 1'b1;
    m_disp = idle_disp(); m_go = 1'b0;
  endtask

  task automatic compare_head();
    exp_t e;
    logic [23:0] got;
    if (exp_q.size() == 0) begin
      check("queue_empty", 24'd1, 24'd0);
      return;
    end
    e = exp_q.pop_front();
    got = {digit5, digit4, digit3, digit2, digit1, digit0};
    $display("txn %-12s disp=%h game_over=%b winner=%0d", e.tag, got, game_over, winner);
    check({e.tag, ".digits"}, got, e.disp);
    check({e.tag, ".game_over"}, {23'd0, game_over}, {23'd0, e.go});
    check({e.tag, ".winner"}, {22'd0, winner}, {22'd0, e.win});
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at the following negedge.
  task automatic cycle(input bit ng, input bit p1, input bit p2, input string tag);
    exp_t e;
    new_game = ng; point_p1 = p1; point_p2 = p2;
    @(posedge clk);
    m_disp = map_disp();
    m_go   = (m_state == 2);
`ifdef SCORE_BLINK_EN
    if (ng || m_state != 2) begin
      m_cnt = 0; m_phase = 1'b1;
    end else if (m_cnt == BDIV - 1) begin
      m_cnt = 0; m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
`endif
    if (ng) begin
      m_state = 1; m_p1 = 0; m_p2 = 0; m_win = 0;
    end else if (m_state == 1 && p1 && !p2) begin
      m_p1++;
      if (m_p1 == WIN) begin m_state = 2; m_win = 1; end
    end else if (m_state == 1 && p2 && !p1) begin
      m_p2++;
      if (m_p2 == WIN) begin m_state = 2; m_win = 2; end
    end
    e.disp = m_disp; e.go = m_go; e.win = 2'(m_win); e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    compare_head();
  endtask

  task automatic push_idle(input string tag);
    exp_t e;
    e.disp = idle_disp(); e.go = 1'b0; e.win = 2'd0; e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    push_idle("reset");
    compare_head();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, "idle");
    cycle(0, 1, 0, "idle_p1");
    cycle(0, 0, 1, "idle_p2");
    cycle(0, 0, 0, "idle");

    cycle(1, 0, 0, "new_game");
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, "p1_point");
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, "p2_point");
    cycle(0, 0, 0, "settle");
    cycle(0, 0, 0, "show_3_2");

    cycle(0, 1, 1, "both_pts");
    cycle(0, 0, 0, "settle");
    cycle(0, 0, 0, "hold_3_2");

    cycle(1, 1, 0, "ng_and_p1");
    cycle(0, 0, 0, "settle");
    cycle(0, 0, 0, "clean_0_0");

    for (int i = 0; i < 2; i++) cycle(0, 0, 1, "p2_point");
    for (int i = 0; i < WIN; i++) cycle(0, 1, 0, "p1_to_win");
    cycle(0, 0, 1, "over_p2");
    cycle(0, 1, 0, "over_p1");
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, "over_blink");

    cycle(1, 0, 0, "new_game");
    for (int i = 0; i < WIN; i++) cycle(0, 0, 1, "p2_to_win");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, "over_p2win");

    cycle(1, 0, 0, "new_game");
    cycle(0, 1, 0, "p1_point");
    cycle(0, 0, 1, "p2_point");
    cycle(0, 0, 0, "mid_play");

    // Asynchronous reset between edges: outputs must clear before any clock.
    #2 reset = 1'b1;
    #1;
    model_reset();
    push_idle("async_reset");
    compare_head();
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 0, "post_reset");
    cycle(1, 0, 0, "new_game");
    cycle(0, 0, 0, "settle");
    cycle(0, 0, 0, "fresh_0_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
